// File: rtl/leg_bus_pkg.sv
// Shared types for the LEG core memory-bus arbiter: FSM states and bus owner tags.
package leg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } bus_owner_t;

endpackage

// File: rtl/bus_beat_counter.sv
// Beat counter for one bus burst; wraps at blocksize and flags the final beat.
module bus_beat_counter #(
  parameter int blocksize = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = (blocksize > 1) ? $clog2(blocksize) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // blocksize is a power of two, so the natural roll-over is the wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CW'(blocksize - 1));

endmodule

// File: rtl/cache_bus_arbiter.sv
// I/D cache arbiter for the single external memory bus; holds a grant for one burst.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin ties, otherwise D-cache wins ties.
import leg_bus_pkg::*;

module cache_bus_arbiter #(
  parameter int blocksize = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IHRequest,
  input  logic [31:0] IHAddr,
  input  logic        DHRequest,
  input  logic        DHWrite,
  input  logic [31:0] DHAddr,
  input  logic [31:0] DHWData,
  input  logic        BusReady,
  output logic        HRequest,
  output logic        HWrite,
  output logic [31:0] HAddr,
  output logic [31:0] HWData,
  output logic        IBusReady,
  output logic        DBusReady,
  output logic        IGrant,
  output logic        DGrant
);

  arb_state_t state_q, state_d;
  bus_owner_t tie_winner;
  logic       owner_req;
  logic       beat_last;
  logic       cnt_clr, cnt_en;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  bus_owner_t last_q, last_d;

  always_comb begin
    tie_winner = (last_q == OWNER_I) ? OWNER_D : OWNER_I;
    last_d     = last_q;
    if (state_q == IDLE && state_d == IGRANT) last_d = OWNER_I;
    if (state_q == IDLE && state_d == DGRANT) last_d = OWNER_D;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= OWNER_I;
    else       last_q <= last_d;
  end
`else
  assign tie_winner = OWNER_D;
`endif

  assign IGrant = (state_q == IGRANT);
  assign DGrant = (state_q == DGRANT);

  assign owner_req = (IGrant & IHRequest) | (DGrant & DHRequest);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (IHRequest && DHRequest)
          state_d = (tie_winner == OWNER_D) ? DGRANT : IGRANT;
        else if (DHRequest)
          state_d = DGRANT;
        else if (IHRequest)
          state_d = IGRANT;
      end
      IGRANT, DGRANT: begin
        // abort takes precedence; both paths force a turnaround cycle in IDLE
        if (!owner_req)                 state_d = IDLE;
        else if (BusReady && beat_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign cnt_clr = (state_q == IDLE) || (state_d == IDLE);
  assign cnt_en  = owner_req && BusReady;

  bus_beat_counter #(.blocksize(blocksize)) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (beat_last)
  );

  always_comb begin
    HRequest = owner_req;
    HWrite   = 1'b0;
    HAddr    = 32'h0;
    HWData   = 32'h0;
    if (IGrant) begin
      HAddr = IHAddr;
    end else if (DGrant) begin
      HWrite = DHWrite;
      HAddr  = DHAddr;
      HWData = DHWData;
    end
  end

  // ready is forwarded even in an abort cycle so the owner sees the beat
  assign IBusReady = IGrant & BusReady;
  assign DBusReady = DGrant & BusReady;

endmodule
